// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Turns the board power-on reset and the PLL lock indication into staged,
//   ordered resets for the rest of the chip. The memory subsystem comes out
//   of reset first. The sequencer then waits for memory init, with a
//   timeout. Peripherals come out next, and the CPU comes out last. Losing
//   PLL lock or a debounced external reset request puts every stage back
//   into reset and restarts the sequence from the lock-wait state.
//
// Ports:
//   clk            in   system clock; this block has no other clock domain
//   reset          in   synchronous, active-high; forces HOLD and reset outputs
//   pll_locked     in   PLL lock, asynchronous; two-flop synchronised (lock_s)
//   ext_rst_req    in   push-button request, asynchronous, active-high;
//                       two-flop synchronised, then debounced (req_db)
//   mem_init_done  in   memory init/calibration complete, synchronous level
//   rst_mem        out  active-high reset to the memory subsystem
//   rst_periph     out  active-high reset to the peripherals
//   rst_cpu        out  active-high reset to the CPU
//   sys_ready      out  high only while the CPU is out of reset
//   init_err       out  sticky flag for a memory-init timeout; only `reset` clears it
// ---------------------------------------------------------------------------
module reset_sequencer #(
    parameter int unsigned STRETCH_CYCLES  = 1024,
    parameter int unsigned MEMINIT_TIMEOUT = 65536,
    parameter int unsigned CPU_DELAY       = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_locked,
    input  logic ext_rst_req,
    input  logic mem_init_done,
    output logic rst_mem,
    output logic rst_periph,
    output logic rst_cpu,
    output logic sys_ready,
    output logic init_err
);

    // -----------------------------------------------------------------------
    // Counter sizing
    // -----------------------------------------------------------------------
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One counter serves every sequencing state. It restarts at zero on each
    // state entry, and its largest terminal value is (largest parameter - 1),
    // so $clog2 of that parameter is enough bits and the counter never wraps.
    localparam int unsigned SEQ_MAX = max3(STRETCH_CYCLES, MEMINIT_TIMEOUT, CPU_DELAY);
    localparam int          CNT_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
    localparam int          DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEMINIT_LAST = CNT_W'(MEMINIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CPU_LAST     = CNT_W'(CPU_DELAY - 1);
    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_LOCK,
        ST_STRETCH,
        ST_MEMINIT,
        ST_PERIPH,
        ST_RUN
    } state_e;

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    logic             lock_meta_q, lock_meta_d;
    logic             lock_s_q,    lock_s_d;
    logic             req_meta_q,  req_meta_d;
    logic             req_s_q,     req_s_d;
    logic [DB_W-1:0]  db_cnt_q,    db_cnt_d;
    logic             req_db_q,    req_db_d;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             init_err_q,  init_err_d;
    logic             rst_mem_q,   rst_mem_d;
    logic             rst_periph_q, rst_periph_d;
    logic             rst_cpu_q,   rst_cpu_d;
    logic             sys_ready_q, sys_ready_d;

    logic             abort;

    // -----------------------------------------------------------------------
    // Input synchronisers and debounce (combinational next-state)
    // -----------------------------------------------------------------------
    always_comb begin
        lock_meta_d = pll_locked;
        lock_s_d    = lock_meta_q;
        req_meta_d  = ext_rst_req;
        req_s_d     = req_meta_q;

        // NOTE: every variable gets a default before any branch. Otherwise a
        // path that skips an assignment would infer a latch.
        db_cnt_d = db_cnt_q;
        req_db_d = req_db_q;

        // The request is accepted once the synchronised level has been high
        // for DEBOUNCE_CYCLES consecutive samples. The count then parks at
        // its last value. Any low sample drops the request and the count at
        // once, so a release takes effect without waiting for a debounce.
        if (!req_s_q) begin
            db_cnt_d = '0;
            req_db_d = 1'b0;
        end else if (db_cnt_q == DB_LAST) begin
            req_db_d = 1'b1;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register (also holds the sync, debounce and output flops)
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples the pre-edge value of the others, with no order dependence.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            req_meta_q   <= 1'b0;
            req_s_q      <= 1'b0;
            db_cnt_q     <= '0;
            req_db_q     <= 1'b0;
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            init_err_q   <= 1'b0;
            rst_mem_q    <= 1'b1;
            rst_periph_q <= 1'b1;
            rst_cpu_q    <= 1'b1;
            sys_ready_q  <= 1'b0;
        end else begin
            lock_meta_q  <= lock_meta_d;
            lock_s_q     <= lock_s_d;
            req_meta_q   <= req_meta_d;
            req_s_q      <= req_s_d;
            db_cnt_q     <= db_cnt_d;
            req_db_q     <= req_db_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_err_q   <= init_err_d;
            rst_mem_q    <= rst_mem_d;
            rst_periph_q <= rst_periph_d;
            rst_cpu_q    <= rst_cpu_d;
            sys_ready_q  <= sys_ready_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // Once the sequence has left WAIT_LOCK, losing lock or a debounced
    // request sends it straight back. This is checked before any other
    // transition, so it overrides a same-cycle advance.
    assign abort = !lock_s_q || req_db_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        init_err_d = init_err_q;

        unique case (state_q)
            ST_HOLD: begin
                state_d = ST_WAIT_LOCK;
            end

            ST_WAIT_LOCK: begin
                if (lock_s_q && !req_db_q) begin
                    state_d = ST_STRETCH;
                    cnt_d   = '0;
                end
            end

            ST_STRETCH: begin
                if (abort) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STRETCH_LAST) begin
                    state_d = ST_MEMINIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_MEMINIT: begin
                if (abort) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (mem_init_done) begin
                    // If done arrives in the same cycle as the timeout, done
                    // takes priority and no error is flagged.
                    state_d = ST_PERIPH;
                    cnt_d   = '0;
                end else if (cnt_q == MEMINIT_LAST) begin
                    state_d    = ST_PERIPH;
                    cnt_d      = '0;
                    init_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_PERIPH: begin
                if (abort) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CPU_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic
    // -----------------------------------------------------------------------
    // Outputs are decoded from the next state and registered, so each reset
    // changes on the same edge as the state transition that causes it. The
    // decode nests one state set inside the next (CPU released implies
    // peripherals released implies memory released), which makes the
    // release order hold by construction.
    always_comb begin
        rst_mem_d    = (state_d == ST_HOLD) || (state_d == ST_WAIT_LOCK) ||
                       (state_d == ST_STRETCH);
        rst_periph_d = rst_mem_d || (state_d == ST_MEMINIT);
        rst_cpu_d    = (state_d != ST_RUN);
        sys_ready_d  = (state_d == ST_RUN);
    end

    assign rst_mem    = rst_mem_q;
    assign rst_periph = rst_periph_q;
    assign rst_cpu    = rst_cpu_q;
    assign sys_ready  = sys_ready_q;
    assign init_err   = init_err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer with small parameters (stretch 16,
// timeout 64, CPU delay 4, debounce 8). Inputs change on the falling edge,
// and outputs are sampled on the falling edge. Latencies below count rising
// edges from the falling edge on which the stimulus changed:
//   lock/request synchroniser: 2 edges; debounce: 8 further edges;
//   FSM output register: 1 edge.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int unsigned STRETCH  = 16;
    localparam int unsigned TIMEOUT  = 64;
    localparam int unsigned CPU_DLY  = 4;
    localparam int unsigned DEBOUNCE = 8;

    logic clk           = 1'b0;
    logic reset         = 1'b1;
    logic pll_locked    = 1'b1;
    logic ext_rst_req   = 1'b0;
    logic mem_init_done = 1'b0;
    logic rst_mem, rst_periph, rst_cpu, sys_ready, init_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .STRETCH_CYCLES (STRETCH),
        .MEMINIT_TIMEOUT(TIMEOUT),
        .CPU_DELAY      (CPU_DLY),
        .DEBOUNCE_CYCLES(DEBOUNCE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .ext_rst_req  (ext_rst_req),
        .mem_init_done(mem_init_done),
        .rst_mem      (rst_mem),
        .rst_periph   (rst_periph),
        .rst_cpu      (rst_cpu),
        .sys_ready    (sys_ready),
        .init_err     (init_err)
    );

    // Advance n rising edges and return on the following falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // The release order must hold on every cycle, whichever test is running.
    always @(negedge clk) begin
        if (!$isunknown({rst_mem, rst_periph, rst_cpu})) begin
            checks++;
            if ((!rst_cpu && rst_periph) || (!rst_periph && rst_mem)) begin
                failures++;
                $display("FAIL release_order t=%0t mem=%b periph=%b cpu=%b expected cpu0->periph0->mem0",
                         $time, rst_mem, rst_periph, rst_cpu);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog bench did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Outputs while reset is held: {mem,periph,cpu,ready,err} = 11100.
    task automatic test_reset();
        reset = 1'b1; pll_locked = 1'b1; ext_rst_req = 1'b0; mem_init_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if ({rst_mem, rst_periph, rst_cpu, sys_ready, init_err} !== 5'b11100) begin
                failures++;
                $display("FAIL reset_values cycle %0d got=%b expected=11100", i,
                         {rst_mem, rst_periph, rst_cpu, sys_ready, init_err});
            end
        end
    endtask

    // Release timeline: a0 HOLD->WAIT_LOCK, a2 STRETCH entry, a18 rst_mem low.
    // The done pulse is sampled at a29 (rst_periph low), and RUN follows at a33.
    task automatic test_normal();
        reset = 1'b0;
        tick(18);
        checks++;
        if (rst_mem !== 1'b1) begin
            failures++; $display("FAIL normal_mem_before got=%b expected=1", rst_mem);
        end
        tick(1);
        checks++;
        if ({rst_mem, rst_periph} !== 2'b01) begin
            failures++; $display("FAIL normal_mem_release got=%b expected=01", {rst_mem, rst_periph});
        end
        tick(10);
        checks++;
        if (rst_periph !== 1'b1) begin
            failures++; $display("FAIL normal_periph_waits got=%b expected=1", rst_periph);
        end
        mem_init_done = 1'b1;
        tick(1);
        mem_init_done = 1'b0;
        checks++;
        if ({rst_periph, rst_cpu, sys_ready} !== 3'b010) begin
            failures++; $display("FAIL normal_periph_release got=%b expected=010", {rst_periph, rst_cpu, sys_ready});
        end
        tick(3);
        checks++;
        if ({rst_cpu, sys_ready} !== 2'b10) begin
            failures++; $display("FAIL normal_cpu_before got=%b expected=10", {rst_cpu, sys_ready});
        end
        tick(1);
        checks++;
        if ({rst_cpu, sys_ready, init_err} !== 3'b010) begin
            failures++; $display("FAIL normal_cpu_release got=%b expected=010", {rst_cpu, sys_ready, init_err});
        end
    endtask

    // MEMINIT entered at a18. The timeout fires at a82 (64 edges later),
    // followed by RUN at a86. A lock loss then re-sequences with done held high.
    task automatic test_timeout();
        reset = 1'b1; mem_init_done = 1'b0; pll_locked = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(19);
        checks++;
        if (rst_mem !== 1'b0) begin
            failures++; $display("FAIL timeout_mem_release got=%b expected=0", rst_mem);
        end
        tick(63);
        checks++;
        if ({rst_periph, init_err} !== 2'b10) begin
            failures++; $display("FAIL timeout_before got=%b expected=10", {rst_periph, init_err});
        end
        tick(1);
        checks++;
        if ({rst_periph, init_err} !== 2'b01) begin
            failures++; $display("FAIL timeout_fire got=%b expected=01", {rst_periph, init_err});
        end
        tick(3);
        checks++;
        if (sys_ready !== 1'b0) begin
            failures++; $display("FAIL timeout_ready_early got=%b expected=0", sys_ready);
        end
        tick(1);
        checks++;
        if ({sys_ready, init_err} !== 2'b11) begin
            failures++; $display("FAIL timeout_run got=%b expected=11", {sys_ready, init_err});
        end
        // Lock loss: two synchroniser edges, and the abort lands on the third.
        pll_locked = 1'b0;
        tick(2);
        checks++;
        if (sys_ready !== 1'b1) begin
            failures++; $display("FAIL lockloss_early got=%b expected=1", sys_ready);
        end
        tick(1);
        checks++;
        if ({rst_mem, rst_periph, rst_cpu, sys_ready, init_err} !== 5'b11101) begin
            failures++; $display("FAIL lockloss_abort got=%b expected=11101",
                                 {rst_mem, rst_periph, rst_cpu, sys_ready, init_err});
        end
        pll_locked = 1'b1; mem_init_done = 1'b1;
        tick(23);
        checks++;
        if (sys_ready !== 1'b0) begin
            failures++; $display("FAIL reseq_ready_early got=%b expected=0", sys_ready);
        end
        tick(1);
        checks++;
        if ({rst_cpu, sys_ready, init_err} !== 3'b011) begin
            failures++; $display("FAIL reseq_err_sticky got=%b expected=011", {rst_cpu, sys_ready, init_err});
        end
    endtask

    // Starts in RUN with init_err=1. Re-sequence into MEMINIT, then assert reset.
    task automatic test_reset_mid_meminit();
        mem_init_done = 1'b0; pll_locked = 1'b0;
        tick(3);
        checks++;
        if ({rst_mem, sys_ready} !== 2'b10) begin
            failures++; $display("FAIL midinit_abort got=%b expected=10", {rst_mem, sys_ready});
        end
        pll_locked = 1'b1;
        tick(19);
        checks++;
        if ({rst_mem, rst_periph, init_err} !== 3'b011) begin
            failures++; $display("FAIL midinit_in_meminit got=%b expected=011", {rst_mem, rst_periph, init_err});
        end
        tick(5);
        reset = 1'b1;
        tick(1);
        checks++;
        if ({rst_mem, rst_periph, rst_cpu, sys_ready, init_err} !== 5'b11100) begin
            failures++; $display("FAIL midinit_reset got=%b expected=11100",
                                 {rst_mem, rst_periph, rst_cpu, sys_ready, init_err});
        end
    endtask

    // STRETCH entry at a2. Lock is driven low after a10, so lock_s is low
    // when the count reads 10 (a13). After relock, a full 16-edge stretch
    // must run again.
    task automatic test_lock_loss_stretch();
        reset = 1'b1; pll_locked = 1'b1; mem_init_done = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(11);
        pll_locked = 1'b0;
        tick(8);
        checks++;
        if (rst_mem !== 1'b1) begin
            failures++; $display("FAIL stretch_abort_mem got=%b expected=1", rst_mem);
        end
        tick(2);
        checks++;
        if (rst_mem !== 1'b1) begin
            failures++; $display("FAIL stretch_waitlock_mem got=%b expected=1", rst_mem);
        end
        pll_locked = 1'b1;
        tick(18);
        checks++;
        if (rst_mem !== 1'b1) begin
            failures++; $display("FAIL restretch_early got=%b expected=1", rst_mem);
        end
        tick(1);
        checks++;
        if (rst_mem !== 1'b0) begin
            failures++; $display("FAIL restretch_release got=%b expected=0", rst_mem);
        end
    endtask

    // External request: a 7-cycle glitch is ignored. A held request aborts
    // on edge 11 (2 sync + 8 debounce + 1 output) and holds WAIT_LOCK.
    task automatic test_ext_req();
        reset = 1'b1; pll_locked = 1'b1; mem_init_done = 1'b1; ext_rst_req = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(24);
        checks++;
        if (sys_ready !== 1'b1) begin
            failures++; $display("FAIL ext_bringup got=%b expected=1", sys_ready);
        end
        ext_rst_req = 1'b1;
        tick(7);
        ext_rst_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            checks++;
            if (sys_ready !== 1'b1) begin
                failures++; $display("FAIL ext_glitch cycle %0d got=%b expected=1", i, sys_ready);
            end
        end
        ext_rst_req = 1'b1;
        tick(10);
        checks++;
        if (sys_ready !== 1'b1) begin
            failures++; $display("FAIL ext_debounce_early got=%b expected=1", sys_ready);
        end
        tick(1);
        checks++;
        if ({rst_mem, rst_periph, rst_cpu, sys_ready, init_err} !== 5'b11100) begin
            failures++; $display("FAIL ext_abort got=%b expected=11100",
                                 {rst_mem, rst_periph, rst_cpu, sys_ready, init_err});
        end
        for (int i = 0; i < 39; i++) begin
            tick(1);
            checks++;
            if (rst_mem !== 1'b1) begin
                failures++; $display("FAIL ext_hold cycle %0d got=%b expected=1", i, rst_mem);
            end
        end
        // Release: req_db falls at f2, STRETCH entry at f3, rst_mem low at
        // f19, RUN at f24.
        ext_rst_req = 1'b0;
        tick(19);
        checks++;
        if (rst_mem !== 1'b1) begin
            failures++; $display("FAIL ext_reseq_early got=%b expected=1", rst_mem);
        end
        tick(1);
        checks++;
        if (rst_mem !== 1'b0) begin
            failures++; $display("FAIL ext_reseq_mem got=%b expected=0", rst_mem);
        end
        tick(5);
        checks++;
        if ({rst_cpu, sys_ready} !== 2'b01) begin
            failures++; $display("FAIL ext_reseq_run got=%b expected=01", {rst_cpu, sys_ready});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_normal();
        test_timeout();
        test_reset_mid_meminit();
        test_lock_loss_stretch();
        test_ext_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
